// File: rtl/interrupt_pc_controller_pkg.sv
// Shared types and defaults for the interrupt front-end: FSM state encoding,
// IRQ index width and the default ISR entry vector.
package interrupt_pc_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SAVE    = 3'd2,
    ST_ACK     = 3'd3,
    ST_ISR     = 3'd4,
    ST_RETURN  = 3'd5
  } state_e;

  localparam int unsigned IRQ_IDX_W          = 5;
  localparam logic [10:0] ISR_VECTOR_DEFAULT = 11'd4;

endpackage

// File: rtl/interrupt_pc_controller_priority_encoder_irq.sv
// Combinational priority encoder over the pending IRQ vector.
// The lowest set index wins, so line 0 has the highest priority.
module priority_encoder_irq
  import interrupt_pc_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]   pending,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  always_comb begin
    valid = |pending;
    idx   = '0;
    // Scanning downwards lets the lowest set index overwrite any higher one.
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (pending[i-1]) idx = IRQ_IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/interrupt_pc_controller.sv
// Interrupt front-end: latches IRQ requests, stalls the core while the
// interrupted PC and IRQ id are handed to the register file, then redirects the PC.
module interrupt_pc_controller
  import interrupt_pc_controller_pkg::*;
#(
  parameter int unsigned          PC_WIDTH   = 11,
  parameter int unsigned          NUM_IRQ    = 8,
  parameter logic [PC_WIDTH-1:0]  ISR_VECTOR = PC_WIDTH'(ISR_VECTOR_DEFAULT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                irqEnable,
  input  logic [PC_WIDTH-1:0] valorPC,
  input  logic                reti,
  output logic [PC_WIDTH-1:0] valorPCBuffer,
  output logic [31:0]         qualInterrupcao,
  output logic                savePCBuffer,
  output logic                getInterruption,
  output logic                stall,
  output logic                pcLoad,
  output logic [PC_WIDTH-1:0] pcTarget,
  output logic                inIsr
);

  state_e                state_q, state_d;
  logic [NUM_IRQ-1:0]    pending_q, pending_d;
  logic [NUM_IRQ-1:0]    clr_mask;
  logic [PC_WIDTH-1:0]   pc_buf_q, pc_buf_d;
  logic [31:0]           qual_q, qual_d;
  logic                  enc_valid;
  logic [IRQ_IDX_W-1:0]  enc_idx;

  priority_encoder_irq #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pending (pending_q),
    .valid   (enc_valid),
    .idx     (enc_idx)
  );

  // The serviced index comes from the id latched in CAPTURE, not the live encoder.
  always_comb begin
    clr_mask = '0;
    if (state_q == ST_ACK) begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (qual_q[IRQ_IDX_W-1:0] == IRQ_IDX_W'(i)) clr_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~clr_mask) | irq;
    pc_buf_d  = pc_buf_q;
    qual_d    = qual_q;
    case (state_q)
      ST_IDLE:    if (enc_valid && irqEnable) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        pc_buf_d = valorPC;
        qual_d   = 32'(enc_idx);
        state_d  = ST_SAVE;
      end
      ST_SAVE:    state_d = ST_ACK;
      ST_ACK:     state_d = ST_ISR;
      ST_ISR:     if (reti) state_d = ST_RETURN;
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      pc_buf_q  <= '0;
      qual_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pc_buf_q  <= pc_buf_d;
      qual_q    <= qual_d;
    end
  end

  // Outputs depend on the registered state only, so they never see input glitches.
  always_comb begin
    savePCBuffer    = 1'b0;
    getInterruption = 1'b0;
    stall           = 1'b0;
    pcLoad          = 1'b0;
    pcTarget        = '0;
    inIsr           = 1'b0;
    case (state_q)
      ST_CAPTURE: stall = 1'b1;
      ST_SAVE: begin
        stall        = 1'b1;
        savePCBuffer = 1'b1;
      end
      ST_ACK: begin
        stall           = 1'b1;
        getInterruption = 1'b1;
        pcLoad          = 1'b1;
        pcTarget        = ISR_VECTOR;
      end
      ST_ISR:     inIsr = 1'b1;
      ST_RETURN: begin
        stall    = 1'b1;
        pcLoad   = 1'b1;
        pcTarget = pc_buf_q;
      end
      default: ;
    endcase
  end

  assign valorPCBuffer   = pc_buf_q;
  assign qualInterrupcao = qual_q;

endmodule

// File: tb/tb_interrupt_pc_controller.sv
// Directed bench for interrupt_pc_controller: entry sequence, priority,
// return path, enable masking and mid-sequence reset.
module tb_interrupt_pc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        irqEnable;
  logic [10:0] valorPC;
  logic        reti;
  logic [10:0] valorPCBuffer;
  logic [31:0] qualInterrupcao;
  logic        savePCBuffer;
  logic        getInterruption;
  logic        stall;
  logic        pcLoad;
  logic [10:0] pcTarget;
  logic        inIsr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_pc_controller #(
    .PC_WIDTH   (11),
    .NUM_IRQ    (8),
    .ISR_VECTOR (11'd4)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .irq             (irq),
    .irqEnable       (irqEnable),
    .valorPC         (valorPC),
    .reti            (reti),
    .valorPCBuffer   (valorPCBuffer),
    .qualInterrupcao (qualInterrupcao),
    .savePCBuffer    (savePCBuffer),
    .getInterruption (getInterruption),
    .stall           (stall),
    .pcLoad          (pcLoad),
    .pcTarget        (pcTarget),
    .inIsr           (inIsr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; irq = '0; reti = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = 8'hFF; irqEnable = 1'b1; valorPC = 11'd55; reti = 1'b0;
    tick(); tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", stall); end
    n_checks++; if (savePCBuffer !== 1'b0) begin n_fail++; $display("FAIL rst_save got=%b exp=0", savePCBuffer); end
    n_checks++; if (getInterruption !== 1'b0) begin n_fail++; $display("FAIL rst_get got=%b exp=0", getInterruption); end
    n_checks++; if (pcLoad !== 1'b0) begin n_fail++; $display("FAIL rst_pcload got=%b exp=0", pcLoad); end
    n_checks++; if (inIsr !== 1'b0) begin n_fail++; $display("FAIL rst_inisr got=%b exp=0", inIsr); end
    n_checks++; if (pcTarget !== 11'd0) begin n_fail++; $display("FAIL rst_pctarget got=%0d exp=0", pcTarget); end
    n_checks++; if (valorPCBuffer !== 11'd0) begin n_fail++; $display("FAIL rst_buf got=%0d exp=0", valorPCBuffer); end
    n_checks++; if (qualInterrupcao !== 32'd0) begin n_fail++; $display("FAIL rst_qual got=%0d exp=0", qualInterrupcao); end
    reset = 1'b1;
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_rel_idle got=%b exp=0", stall); end
    irq = '0;
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_rel_capture got=%b exp=1", stall); end
    tick();
    n_checks++; if (savePCBuffer !== 1'b1) begin n_fail++; $display("FAIL rst_rel_save got=%b exp=1", savePCBuffer); end
    n_checks++; if (qualInterrupcao !== 32'd0) begin n_fail++; $display("FAIL rst_rel_qual got=%0d exp=0", qualInterrupcao); end
    n_checks++; if (valorPCBuffer !== 11'd55) begin n_fail++; $display("FAIL rst_rel_buf got=%0d exp=55", valorPCBuffer); end
  endtask

  task automatic test_single_irq();
    do_reset();
    irqEnable = 1'b1; valorPC = 11'd100; irq = 8'h08;
    tick();
    irq = '0;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL s_pend_stall got=%b exp=0", stall); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL s_cap_stall got=%b exp=1", stall); end
    n_checks++; if (savePCBuffer !== 1'b0) begin n_fail++; $display("FAIL s_cap_save got=%b exp=0", savePCBuffer); end
    n_checks++; if (pcLoad !== 1'b0) begin n_fail++; $display("FAIL s_cap_pcload got=%b exp=0", pcLoad); end
    tick();
    valorPC = 11'd200;
    n_checks++; if (savePCBuffer !== 1'b1) begin n_fail++; $display("FAIL s_save got=%b exp=1", savePCBuffer); end
    n_checks++; if (getInterruption !== 1'b0) begin n_fail++; $display("FAIL s_save_get got=%b exp=0", getInterruption); end
    n_checks++; if (valorPCBuffer !== 11'd100) begin n_fail++; $display("FAIL s_save_buf got=%0d exp=100", valorPCBuffer); end
    n_checks++; if (qualInterrupcao !== 32'd3) begin n_fail++; $display("FAIL s_save_qual got=%0d exp=3", qualInterrupcao); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL s_save_stall got=%b exp=1", stall); end
    tick();
    n_checks++; if (savePCBuffer !== 1'b0) begin n_fail++; $display("FAIL s_ack_save got=%b exp=0", savePCBuffer); end
    n_checks++; if (getInterruption !== 1'b1) begin n_fail++; $display("FAIL s_ack_get got=%b exp=1", getInterruption); end
    n_checks++; if (pcLoad !== 1'b1) begin n_fail++; $display("FAIL s_ack_pcload got=%b exp=1", pcLoad); end
    n_checks++; if (pcTarget !== 11'd4) begin n_fail++; $display("FAIL s_ack_target got=%0d exp=4", pcTarget); end
    n_checks++; if (qualInterrupcao !== 32'd3) begin n_fail++; $display("FAIL s_ack_qual got=%0d exp=3", qualInterrupcao); end
    tick();
    n_checks++; if (inIsr !== 1'b1) begin n_fail++; $display("FAIL s_isr got=%b exp=1", inIsr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL s_isr_stall got=%b exp=0", stall); end
    n_checks++; if (pcLoad !== 1'b0) begin n_fail++; $display("FAIL s_isr_pcload got=%b exp=0", pcLoad); end
    tick(); tick();
    n_checks++; if (inIsr !== 1'b1) begin n_fail++; $display("FAIL s_isr_hold got=%b exp=1", inIsr); end
    reti = 1'b1;
    tick();
    reti = 1'b0;
    n_checks++; if (pcLoad !== 1'b1) begin n_fail++; $display("FAIL s_ret_pcload got=%b exp=1", pcLoad); end
    n_checks++; if (pcTarget !== 11'd100) begin n_fail++; $display("FAIL s_ret_target got=%0d exp=100", pcTarget); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL s_ret_stall got=%b exp=1", stall); end
    n_checks++; if (inIsr !== 1'b0) begin n_fail++; $display("FAIL s_ret_inisr got=%b exp=0", inIsr); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL s_idle_stall got=%b exp=0", stall); end
    n_checks++; if (pcTarget !== 11'd0) begin n_fail++; $display("FAIL s_idle_target got=%0d exp=0", pcTarget); end
  endtask

  task automatic test_priority();
    do_reset();
    irqEnable = 1'b1; valorPC = 11'd300; irq = 8'b0001_0100;
    tick();
    irq = '0;
    tick();
    tick();
    n_checks++; if (qualInterrupcao !== 32'd2) begin n_fail++; $display("FAIL p_first_qual got=%0d exp=2", qualInterrupcao); end
    n_checks++; if (valorPCBuffer !== 11'd300) begin n_fail++; $display("FAIL p_first_buf got=%0d exp=300", valorPCBuffer); end
    tick();
    n_checks++; if (getInterruption !== 1'b1) begin n_fail++; $display("FAIL p_first_get got=%b exp=1", getInterruption); end
    tick();
    valorPC = 11'd7;
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    n_checks++; if (pcTarget !== 11'd300) begin n_fail++; $display("FAIL p_ret_target got=%0d exp=300", pcTarget); end
    valorPC = 11'd300;
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL p_idle_stall got=%b exp=0", stall); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL p_second_cap got=%b exp=1", stall); end
    tick();
    n_checks++; if (qualInterrupcao !== 32'd4) begin n_fail++; $display("FAIL p_second_qual got=%0d exp=4", qualInterrupcao); end
    n_checks++; if (valorPCBuffer !== 11'd300) begin n_fail++; $display("FAIL p_second_buf got=%0d exp=300", valorPCBuffer); end
    tick();
    n_checks++; if (pcTarget !== 11'd4) begin n_fail++; $display("FAIL p_second_target got=%0d exp=4", pcTarget); end
  endtask

  task automatic test_irq_in_isr();
    do_reset();
    irqEnable = 1'b1; valorPC = 11'd50; irq = 8'h20;
    tick();
    irq = '0;
    tick(); tick();
    n_checks++; if (qualInterrupcao !== 32'd5) begin n_fail++; $display("FAIL n_save_qual got=%0d exp=5", qualInterrupcao); end
    tick(); tick();
    valorPC = 11'd9; irq = 8'h01;
    tick();
    irq = '0;
    n_checks++; if (inIsr !== 1'b1) begin n_fail++; $display("FAIL n_isr_nonest got=%b exp=1", inIsr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL n_isr_stall got=%b exp=0", stall); end
    n_checks++; if (qualInterrupcao !== 32'd5) begin n_fail++; $display("FAIL n_isr_qual got=%0d exp=5", qualInterrupcao); end
    reti = 1'b1;
    tick();
    reti = 1'b0; valorPC = 11'd50;
    n_checks++; if (pcTarget !== 11'd50) begin n_fail++; $display("FAIL n_ret_target got=%0d exp=50", pcTarget); end
    n_checks++; if (pcLoad !== 1'b1) begin n_fail++; $display("FAIL n_ret_pcload got=%b exp=1", pcLoad); end
    tick();
    n_checks++; if (inIsr !== 1'b0) begin n_fail++; $display("FAIL n_idle_inisr got=%b exp=0", inIsr); end
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL n_reentry_cap got=%b exp=1", stall); end
    tick();
    n_checks++; if (qualInterrupcao !== 32'd0) begin n_fail++; $display("FAIL n_reentry_qual got=%0d exp=0", qualInterrupcao); end
    n_checks++; if (valorPCBuffer !== 11'd50) begin n_fail++; $display("FAIL n_reentry_buf got=%0d exp=50", valorPCBuffer); end
    n_checks++; if (savePCBuffer !== 1'b1) begin n_fail++; $display("FAIL n_reentry_save got=%b exp=1", savePCBuffer); end
  endtask

  task automatic test_enable_mask();
    do_reset();
    irqEnable = 1'b0; valorPC = 11'd77; irq = 8'h02;
    tick();
    irq = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL e_masked_%0d got=%b exp=0", i, stall); end
    end
    irqEnable = 1'b1;
    tick();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL e_enabled_cap got=%b exp=1", stall); end
    irqEnable = 1'b0;
    tick();
    n_checks++; if (savePCBuffer !== 1'b1) begin n_fail++; $display("FAIL e_noabort_save got=%b exp=1", savePCBuffer); end
    n_checks++; if (qualInterrupcao !== 32'd1) begin n_fail++; $display("FAIL e_qual got=%0d exp=1", qualInterrupcao); end
    tick();
    n_checks++; if (getInterruption !== 1'b1) begin n_fail++; $display("FAIL e_noabort_get got=%b exp=1", getInterruption); end
    tick();
    n_checks++; if (inIsr !== 1'b1) begin n_fail++; $display("FAIL e_noabort_isr got=%b exp=1", inIsr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irqEnable = 1'b1; valorPC = 11'd123; irq = 8'h08;
    tick();
    irq = '0;
    tick(); tick();
    n_checks++; if (savePCBuffer !== 1'b1) begin n_fail++; $display("FAIL r_pre_save got=%b exp=1", savePCBuffer); end
    reset = 1'b0;
    tick();
    n_checks++; if (savePCBuffer !== 1'b0) begin n_fail++; $display("FAIL r_save got=%b exp=0", savePCBuffer); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r_stall got=%b exp=0", stall); end
    n_checks++; if (valorPCBuffer !== 11'd0) begin n_fail++; $display("FAIL r_buf got=%0d exp=0", valorPCBuffer); end
    n_checks++; if (qualInterrupcao !== 32'd0) begin n_fail++; $display("FAIL r_qual got=%0d exp=0", qualInterrupcao); end
    reset = 1'b1; reti = 1'b1;
    tick();
    reti = 1'b0;
    n_checks++; if (pcLoad !== 1'b0) begin n_fail++; $display("FAIL r_reti_ignored got=%b exp=0", pcLoad); end
    n_checks++; if (inIsr !== 1'b0) begin n_fail++; $display("FAIL r_reti_inisr got=%b exp=0", inIsr); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r_pending_cleared got=%b exp=0", stall); end
  endtask

  initial begin
    test_reset();
    test_single_irq();
    test_priority();
    test_irq_in_isr();
    test_enable_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
